// File: rtl/wakeup_scoreboard.sv
// Register wakeup scoreboard: tracks pending writers per architectural register
// and reports whether source operands can be read from the register file or bypass.
module wakeup_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int AW      = 5,
    parameter int SRC_NUM = 2,
    parameter int BC_NUM  = 2,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic                    issue_valid,
    input  logic                    issue_we,
    input  logic [AW-1:0]           issue_waddr,
    output logic [TAG_W-1:0]        issue_tag,
    output logic                    issue_stall,
    input  logic [BC_NUM-1:0]       bc_valid,
    input  logic [BC_NUM*TAG_W-1:0] bc_tag,
    input  logic [BC_NUM*AW-1:0]    bc_waddr,
    input  logic                    wb_valid,
    input  logic [AW-1:0]           wb_waddr,
    input  logic [SRC_NUM-1:0]      src_en,
    input  logic [SRC_NUM*AW-1:0]   src_addr,
    output logic [SRC_NUM-1:0]      src_ready,
    output logic                    all_ready
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] pend_cnt_q [REG_NUM];
    logic [CNT_W-1:0] pend_cnt_d [REG_NUM];
    logic [TAG_W-1:0] last_tag_q [REG_NUM];
    logic [TAG_W-1:0] last_tag_d [REG_NUM];
    logic             last_rdy_q [REG_NUM];
    logic             last_rdy_d [REG_NUM];
    logic [TAG_W-1:0] next_tag_q;
    logic [TAG_W-1:0] next_tag_d;

    logic issue_hit;
    logic wb_hit;

    // A retiring write to the same register frees a slot in the same cycle.
    assign issue_stall = issue_valid && issue_we && (issue_waddr != '0) &&
                         (pend_cnt_q[issue_waddr] == CNT_MAX) &&
                         !(wb_valid && (wb_waddr == issue_waddr));
    assign issue_tag   = next_tag_q;
    assign issue_hit   = issue_valid && issue_we && (issue_waddr != '0) && !issue_stall;
    assign wb_hit      = wb_valid && (wb_waddr != '0);
    assign next_tag_d  = (issue_valid && !issue_stall) ? next_tag_q + TAG_W'(1) : next_tag_q;

    always_comb begin
        logic iss_r;
        logic wb_r;
        pend_cnt_d = pend_cnt_q;
        last_tag_d = last_tag_q;
        last_rdy_d = last_rdy_q;
        iss_r      = 1'b0;
        wb_r       = 1'b0;
        // Register 0 is skipped so it can never become pending.
        for (int r = 1; r < REG_NUM; r++) begin
            iss_r = issue_hit && (issue_waddr == AW'(r));
            wb_r  = wb_hit && (wb_waddr == AW'(r));
            if (flush) begin
                pend_cnt_d[r] = '0;
                last_rdy_d[r] = 1'b1;
            end else begin
                for (int i = 0; i < BC_NUM; i++) begin
                    if (bc_valid[i] && (bc_waddr[i*AW +: AW] == AW'(r)) &&
                        (bc_tag[i*TAG_W +: TAG_W] == last_tag_q[r]) && !iss_r)
                        last_rdy_d[r] = 1'b1;
                end
                if (iss_r && !wb_r) begin
                    pend_cnt_d[r] = pend_cnt_q[r] + CNT_W'(1);
                end else if (wb_r && !iss_r && (pend_cnt_q[r] != '0)) begin
                    pend_cnt_d[r] = pend_cnt_q[r] - CNT_W'(1);
                    if (pend_cnt_q[r] == CNT_W'(1))
                        last_rdy_d[r] = 1'b1;
                end
                if (iss_r) begin
                    last_tag_d[r] = issue_tag;
                    last_rdy_d[r] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic [AW-1:0] sa;
        sa        = '0;
        src_ready = '0;
        for (int j = 0; j < SRC_NUM; j++) begin
            sa = src_addr[j*AW +: AW];
            src_ready[j] = !src_en[j] || (sa == '0) || (pend_cnt_q[sa] == '0) || last_rdy_q[sa];
            for (int i = 0; i < BC_NUM; i++) begin
                if (bc_valid[i] && (bc_waddr[i*AW +: AW] == sa) &&
                    (bc_tag[i*TAG_W +: TAG_W] == last_tag_q[sa]))
                    src_ready[j] = 1'b1;
            end
        end
    end

    assign all_ready = &src_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < REG_NUM; r++) begin
                pend_cnt_q[r] <= '0;
                last_tag_q[r] <= '0;
                last_rdy_q[r] <= 1'b1;
            end
            next_tag_q <= '0;
        end else begin
            pend_cnt_q <= pend_cnt_d;
            last_tag_q <= last_tag_d;
            last_rdy_q <= last_rdy_d;
            next_tag_q <= next_tag_d;
        end
    end

endmodule
